sdrc_responder: RTL and testbench

SDRC_RESPONDER -- requirements
Module: sdrc_responder

---
 rtl/sdrc_responder.sv | 194 +++++++++++++++++++
 tb/tb_sdrc_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_responder.sv
// User-side SDRAM controller responder: accepts activate/read/write/refresh/
// precharge-all commands and serves them from an internal word memory with
// the cycle timing of a real SDRAM controller front end.
module sdrc_responder #(
   parameter int unsigned INIT_CYCLES  = 16,
   parameter int unsigned ADDRESS_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        I_sdrc_cmd_en,
   input  logic [2:0]  I_sdrc_cmd,
   input  logic        I_sdrc_precharge_ctrl,
   input  logic [20:0] I_sdrc_addr,
   input  logic [3:0]  I_sdrc_dqm,
   input  logic [31:0] I_sdrc_data,
   input  logic [7:0]  I_sdrc_data_len,
   output logic [31:0] O_sdrc_data,
   output logic        O_sdrc_init_done,
   output logic        O_sdrc_cmd_ack,
   output logic        O_protocol_err
);

   localparam int unsigned Depth = 2 ** ADDRESS_BITS;
   localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

   localparam logic [2:0] CmdRefresh   = 3'b001;
   localparam logic [2:0] CmdPrecharge = 3'b010;
   localparam logic [2:0] CmdAct       = 3'b011;
   localparam logic [2:0] CmdWrite     = 3'b100;
   localparam logic [2:0] CmdRead      = 3'b101;

   typedef enum logic [2:0] {
      StInit, StIdle, StAct, StWrite, StWrec, StRead, StWait
   } state_e;

   state_e            state_q;
   logic [InitW-1:0]  init_cnt_q;
   // Edges since the accepting edge: holds e while edge e is being evaluated.
   logic [8:0]        cnt_q;
   logic [8:0]        wait_end_q;
   logic [1:0]        bank_q;
   logic [10:0]       row_q;
   logic [7:0]        col_q;
   logic [7:0]        len_q;
   logic              auto_pc_q;
   logic [3:0]        bank_open_q;
   logic [3:0][10:0]  open_row_q;

   logic [31:0]       mem [Depth];

   logic                    accept;
   logic                    access_ok;
   logic                    wr_en;
   logic [ADDRESS_BITS-1:0] wr_idx;
   logic [ADDRESS_BITS-1:0] rd_idx;
   logic [7:0]              rd_off;

   function automatic logic [ADDRESS_BITS-1:0] mem_idx(input logic [1:0]  bank,
                                                       input logic [10:0] row,
                                                       input logic [7:0]  col);
      logic [20:0] full;
      full = {bank, row, col};
      return full[ADDRESS_BITS-1:0];
   endfunction

   assign accept    = (state_q == StIdle) && I_sdrc_cmd_en;
   assign access_ok = bank_open_q[I_sdrc_addr[20:19]] &&
                      (open_row_q[I_sdrc_addr[20:19]] == I_sdrc_addr[18:8]);
   assign rd_off    = cnt_q[7:0] - 8'd4;
   assign rd_idx    = mem_idx(bank_q, row_q, col_q + rd_off);

   // Write port: word 0 goes in with the command, later words from WRITE.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = mem_idx(I_sdrc_addr[20:19], I_sdrc_addr[18:8], I_sdrc_addr[7:0]);
      if (accept && (I_sdrc_cmd == CmdWrite)) begin
         wr_en = 1'b1;
      end else if (state_q == StWrite) begin
         wr_en  = 1'b1;
         wr_idx = mem_idx(bank_q, row_q, col_q + cnt_q[7:0]);
      end
   end

   // Byte-masked memory write; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (!I_sdrc_dqm[0]) mem[wr_idx][7:0]   <= I_sdrc_data[7:0];
         if (!I_sdrc_dqm[1]) mem[wr_idx][15:8]  <= I_sdrc_data[15:8];
         if (!I_sdrc_dqm[2]) mem[wr_idx][23:16] <= I_sdrc_data[23:16];
         if (!I_sdrc_dqm[3]) mem[wr_idx][31:24] <= I_sdrc_data[31:24];
      end
   end

   // Command FSM with registered outputs and bank bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= StInit;
         init_cnt_q       <= '0;
         cnt_q            <= '0;
         wait_end_q       <= '0;
         bank_q           <= '0;
         row_q            <= '0;
         col_q            <= '0;
         len_q            <= '0;
         auto_pc_q        <= 1'b0;
         bank_open_q      <= '0;
         open_row_q       <= '0;
         O_sdrc_data      <= '0;
         O_sdrc_init_done <= 1'b0;
         O_sdrc_cmd_ack   <= 1'b0;
         O_protocol_err   <= 1'b0;
      end else begin
         O_sdrc_cmd_ack <= 1'b0;
         cnt_q          <= cnt_q + 9'd1;
         if (I_sdrc_cmd_en && (state_q != StIdle)) O_protocol_err <= 1'b1;
         unique case (state_q)
            StInit: begin
               if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
                  state_q          <= StIdle;
                  O_sdrc_init_done <= 1'b1;
               end else begin
                  init_cnt_q <= init_cnt_q + 1'b1;
               end
            end
            StIdle: begin
               cnt_q     <= 9'd1;
               bank_q    <= I_sdrc_addr[20:19];
               row_q     <= I_sdrc_addr[18:8];
               col_q     <= I_sdrc_addr[7:0];
               len_q     <= I_sdrc_data_len;
               auto_pc_q <= I_sdrc_precharge_ctrl;
               if (I_sdrc_cmd_en) begin
                  case (I_sdrc_cmd)
                     CmdAct: begin
                        if (bank_open_q[I_sdrc_addr[20:19]]) O_protocol_err <= 1'b1;
                        bank_open_q[I_sdrc_addr[20:19]] <= 1'b1;
                        open_row_q[I_sdrc_addr[20:19]]  <= I_sdrc_addr[18:8];
                        state_q <= StAct;
                     end
                     CmdWrite: begin
                        if (!access_ok) O_protocol_err <= 1'b1;
                        state_q <= (I_sdrc_data_len == 8'd0) ? StWrec : StWrite;
                     end
                     CmdRead: begin
                        if (!access_ok) O_protocol_err <= 1'b1;
                        state_q <= StRead;
                     end
                     CmdRefresh: begin
                        wait_end_q <= 9'd9;
                        state_q    <= StWait;
                     end
                     CmdPrecharge: begin
                        bank_open_q <= '0;
                        wait_end_q  <= 9'd3;
                        state_q     <= StWait;
                     end
                     default: ;
                  endcase
               end
            end
            StAct: begin
               O_sdrc_cmd_ack <= 1'b1;
               state_q        <= StIdle;
            end
            StWrite: begin
               if (cnt_q[7:0] == len_q) state_q <= StWrec;
            end
            StWrec: begin
               if (cnt_q == ({1'b0, len_q} + 9'd4)) begin
                  O_sdrc_cmd_ack <= 1'b1;
                  state_q        <= StIdle;
                  if (auto_pc_q) bank_open_q[bank_q] <= 1'b0;
               end
            end
            StRead: begin
               // Four-edge CAS latency before the first word.
               if (cnt_q >= 9'd4) O_sdrc_data <= mem[rd_idx];
               if (cnt_q == ({1'b0, len_q} + 9'd4)) begin
                  state_q <= StIdle;
                  if (auto_pc_q) bank_open_q[bank_q] <= 1'b0;
               end
            end
            StWait: begin
               if (cnt_q == wait_end_q) begin
                  O_sdrc_cmd_ack <= 1'b1;
                  state_q        <= StIdle;
               end
            end
            default: state_q <= StInit;
         endcase
      end
   end

endmodule

// File: tb/tb_sdrc_responder.sv
// Scoreboard bench for sdrc_responder: the driver pushes timed expectations,
// a monitor compares outputs against them every cycle.
module tb_sdrc_responder;

   localparam int unsigned INIT_CYCLES  = 16;
   localparam int unsigned ADDRESS_BITS = 12;
   localparam int          INF          = 32'h7fffffff;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_en = 1'b0;
   logic [2:0]  cmd = '0;
   logic        pc = 1'b0;
   logic [20:0] addr = '0;
   logic [3:0]  dqm = '0;
   logic [31:0] wdata = '0;
   logic [7:0]  len = '0;
   logic [31:0] rdata;
   logic        init_done;
   logic        ack;
   logic        err;

   sdrc_responder #(
      .INIT_CYCLES (INIT_CYCLES),
      .ADDRESS_BITS(ADDRESS_BITS)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .I_sdrc_cmd_en        (cmd_en),
      .I_sdrc_cmd           (cmd),
      .I_sdrc_precharge_ctrl(pc),
      .I_sdrc_addr          (addr),
      .I_sdrc_dqm           (dqm),
      .I_sdrc_data          (wdata),
      .I_sdrc_data_len      (len),
      .O_sdrc_data          (rdata),
      .O_sdrc_init_done     (init_done),
      .O_sdrc_cmd_ack       (ack),
      .O_protocol_err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } rd_t;

   int  ack_q[$];
   rd_t rd_q[$];
   int  err_from  = INF;
   int  init_edge = INF;
   int  next_ok   = INF;

   logic [31:0] mem_m [int];
   bit          open_m [4];
   int          row_m [4];
   logic [31:0] wbuf [256];
   logic [3:0]  mbuf [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int midx(input int b, input int r, input int c);
      return ((b << 19) | (r << 8) | (c & 255)) & ((1 << ADDRESS_BITS) - 1);
   endfunction

   task automatic err_at(input int e);
      if (e < err_from) err_from = e;
   endtask

   // Monitor: compares every cycle against what the driver predicted.
   initial begin
      bit  exp_ack;
      rd_t r;
      forever begin
         @(posedge clk);
         #1;
         exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
         if (exp_ack) void'(ack_q.pop_front());
         check("ack", {31'd0, ack}, {31'd0, exp_ack});
         check("init_done", {31'd0, init_done}, {31'd0, cyc >= init_edge});
         check("protocol_err", {31'd0, err}, {31'd0, cyc >= err_from});
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            r = rd_q.pop_front();
            check("read_data", rdata, r.val);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic wait_ready();
      while (cyc + 1 < next_ok) @(negedge clk);
   endtask

   task automatic do_act(input int b, input int r);
      int e;
      wait_ready();
      e = cyc + 1;
      if (open_m[b]) err_at(e);
      open_m[b] = 1'b1;
      row_m[b]  = r;
      cmd_en = 1'b1; cmd = 3'b011; addr = {2'(b), 11'(r), 8'd0};
      ack_q.push_back(e + 1);
      next_ok = e + 2;
      @(negedge clk);
      cmd_en = 1'b0;
   endtask

   task automatic do_write(input int b, input int r, input int c, input int l, input bit apc);
      int          e;
      int          idx;
      logic [31:0] o;
      wait_ready();
      e = cyc + 1;
      if (!(open_m[b] && row_m[b] == r)) err_at(e);
      cmd_en = 1'b1; cmd = 3'b100; addr = {2'(b), 11'(r), 8'(c)}; len = 8'(l); pc = apc;
      for (int k = 0; k <= l; k++) begin
         wdata = wbuf[k];
         dqm   = mbuf[k];
         idx   = midx(b, r, c + k);
         if (mbuf[k] == 4'h0) begin
            mem_m[idx] = wbuf[k];
         end else if (mem_m.exists(idx)) begin
            o = mem_m[idx];
            for (int j = 0; j < 4; j++) if (!mbuf[k][j]) o[8*j +: 8] = wbuf[k][8*j +: 8];
            mem_m[idx] = o;
         end
         @(negedge clk);
         cmd_en = 1'b0;
      end
      dqm = 4'h0;
      ack_q.push_back(e + l + 4);
      next_ok = e + l + 5;
      if (apc) open_m[b] = 1'b0;
   endtask

   task automatic do_read(input int b, input int r, input int c, input int l, input bit apc,
                          input bit poke);
      int  e;
      int  idx;
      rd_t x;
      wait_ready();
      e = cyc + 1;
      if (!(open_m[b] && row_m[b] == r)) err_at(e);
      cmd_en = 1'b1; cmd = 3'b101; addr = {2'(b), 11'(r), 8'(c)}; len = 8'(l); pc = apc;
      for (int k = 0; k <= l; k++) begin
         idx = midx(b, r, c + k);
         if (mem_m.exists(idx)) begin
            x.cyc = e + 4 + k;
            x.val = mem_m[idx];
            rd_q.push_back(x);
         end
      end
      next_ok = e + l + 5;
      if (apc) open_m[b] = 1'b0;
      @(negedge clk);
      cmd_en = 1'b0;
      if (poke) begin
         // Strobe while the read is still running: must be ignored and flagged.
         cmd_en = 1'b1; cmd = 3'b001;
         err_at(cyc + 1);
         @(negedge clk);
         cmd_en = 1'b0;
      end
   endtask

   task automatic do_misc(input logic [2:0] code);
      int e;
      wait_ready();
      e = cyc + 1;
      cmd_en = 1'b1; cmd = code;
      if (code == 3'b001) begin
         ack_q.push_back(e + 9);
         next_ok = e + 10;
      end else if (code == 3'b010) begin
         ack_q.push_back(e + 3);
         next_ok = e + 4;
         for (int i = 0; i < 4; i++) open_m[i] = 1'b0;
      end else begin
         next_ok = e + 1;
      end
      @(negedge clk);
      cmd_en = 1'b0;
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      cmd_en = 1'b0;
      ack_q.delete();
      rd_q.delete();
      err_from  = INF;
      init_edge = INF;
      for (int i = 0; i < 4; i++) open_m[i] = 1'b0;
      #1;
      check("reset_data", rdata, 32'h0);
      check("reset_ack", {31'd0, ack}, 32'h0);
      check("reset_init_done", {31'd0, init_done}, 32'h0);
      check("reset_err", {31'd0, err}, 32'h0);
      repeat (hold) @(negedge clk);
      rst = 1'b0;
      init_edge = cyc + INIT_CYCLES;
      next_ok   = init_edge + 1;
   endtask

   initial begin
      int b;
      int sel;
      int l;
      int c;
      #1;
      @(negedge clk);
      do_reset(3);

      // Eight-word write then read-back of the same row.
      do_act(0, 0);
      wbuf[0] = 32'h12345678;
      for (int k = 1; k < 7; k++) wbuf[k] = 32'habcdef00 + 32'(k);
      wbuf[7] = 32'habcdef04;
      for (int k = 0; k < 8; k++) mbuf[k] = 4'h0;
      do_write(0, 0, 0, 7, 1'b1);
      do_act(0, 0);
      do_read(0, 0, 0, 7, 1'b1, 1'b0);

      // Byte mask keeps masked lanes of the old word.
      do_act(0, 2);
      wbuf[0] = 32'hffffffff; mbuf[0] = 4'h0;
      do_write(0, 2, 4, 0, 1'b0);
      wbuf[0] = 32'h1e1f2a2b; mbuf[0] = 4'b0011;
      do_write(0, 2, 4, 0, 1'b0);
      do_read(0, 2, 4, 0, 1'b1, 1'b0);

      // Column wrap inside the row.
      do_act(0, 1);
      wbuf[0] = 32'ha5a5_0001; wbuf[1] = 32'h5a5a_0002; mbuf[0] = 4'h0; mbuf[1] = 4'h0;
      do_write(0, 1, 8'hff, 1, 1'b0);
      do_read(0, 1, 8'hff, 0, 1'b0, 1'b0);
      do_read(0, 1, 8'h00, 0, 1'b1, 1'b0);

      // Random legal traffic.
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         b   = $urandom_range(0, 3);
         if (sel == 0) begin
            do_misc(($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010);
         end else if (sel == 1) begin
            sel = $urandom_range(0, 2);
            do_misc((sel == 0) ? 3'b000 : ((sel == 1) ? 3'b110 : 3'b111));
         end else if (!open_m[b]) begin
            do_act(b, $urandom_range(0, 3));
         end else begin
            l = $urandom_range(0, 15);
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 31);
            if (sel < 6) begin
               for (int k = 0; k <= l; k++) begin
                  wbuf[k] = $urandom;
                  mbuf[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
               end
               do_write(b, row_m[b], c, l, ($urandom_range(0, 3) == 0));
            end else begin
               do_read(b, row_m[b], c, l, ($urandom_range(0, 3) == 0), 1'b0);
            end
         end
      end

      // Strobe during a burst flags an error.
      do_misc(3'b010);
      do_act(1, 5);
      do_read(1, 5, 0, 3, 1'b1, 1'b1);

      // Reset during read word 3; memory must survive.
      do_reset(2);
      do_act(0, 0);
      for (int k = 0; k < 8; k++) begin
         wbuf[k] = 32'hc0de_0000 + 32'(k * 17);
         mbuf[k] = 4'h0;
      end
      do_write(0, 0, 8'h10, 7, 1'b0);
      do_read(0, 0, 8'h10, 7, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      do_reset(2);
      do_act(0, 0);
      do_read(0, 0, 8'h10, 7, 1'b1, 1'b0);

      // Access to a row that is not the open one.
      do_act(2, 0);
      do_read(2, 1, 0, 2, 1'b1, 1'b0);
      do_misc(3'b001);

      wait_ready();
      repeat (5) @(negedge clk);
      check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
      check("read_queue_drained", 32'(rd_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
